// File: rtl/aes_tx_serializer.sv
// Block FIFO feeding a MSB-first beat serialiser with valid/ready on both sides.
// Optional even-parity output per beat when AES_TX_PARITY_EN is defined.
module aes_tx_serializer #(
  parameter int BLOCK_W = 128,
  parameter int OUT_W   = 8,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BLOCK_W-1:0]       in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   blk_cnt,
  output logic                     busy
`ifdef AES_TX_PARITY_EN
  ,
  output logic                     out_par
`endif
);

  localparam int BEATS = BLOCK_W / OUT_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BLOCK_W-1:0]   shift_q, shift_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic                 vld_q, vld_d;
  logic                 par_q, par_d;
  logic [BLOCK_W-1:0]   mem_q [DEPTH];
  logic                 push, pop, hs;

  assign in_ready  = !rst && (cnt_q != FULL_CNT);
  assign push      = in_valid && in_ready;
  assign hs        = vld_q && out_ready;
  assign out_valid = vld_q;
  assign out_data  = shift_q[BLOCK_W-1 -: OUT_W];
  assign out_last  = (state_q == S_SEND) && (beat_q == LAST_BEAT);
  assign blk_cnt   = cnt_q;
  assign busy      = (cnt_q != '0) || (state_q == S_SEND);
`ifdef AES_TX_PARITY_EN
  assign out_par   = par_q;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    beat_d  = beat_q;
    vld_d   = vld_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          beat_d  = '0;
          vld_d   = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (hs) begin
          if (beat_q != LAST_BEAT) begin
            shift_d = shift_q << OUT_W;
            beat_d  = beat_q + BW'(1);
          end else if (cnt_q != '0) begin
            // chain straight into the next block so the stream has no bubble
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            beat_d  = '0;
          end else begin
            vld_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    par_d    = ^shift_d[BLOCK_W-1 -: OUT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      beat_q   <= '0;
      vld_q    <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      beat_q   <= beat_d;
      vld_q    <= vld_d;
      par_q    <= par_d;
    end
  end

  // block storage needs no reset; pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule
